// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer: FSM state
// encoding, trap cause codes, instruction width and an alignment helper.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_TRAP = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
  localparam logic [3:0] CAUSE_BREAK      = 4'd3;
  localparam logic [3:0] CAUSE_ECALL      = 4'd11;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux for the RUN state plus target alignment check.
// Outside RUN, or when halted/stalled in RUN, the current PC is held.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = 32'h00000100
) (
  input  state_t      st,
  input  logic [31:0] pc,
  input  logic [31:0] epc,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        trap_req,
  input  logic        mret,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_next,
  output logic        redirect,
  output logic        misaligned
);

  logic [31:0] tgt;
  logic        check_align;
  logic        taken;

  always_comb begin
    pc_next     = pc;
    redirect    = 1'b0;
    misaligned  = 1'b0;
    tgt         = pc + INSTR_BYTES;
    check_align = 1'b0;
    taken       = 1'b0;
    if (st == ST_RUN && !halt_req && !stall) begin
      if (trap_req) begin
        pc_next = TRAP_VECTOR;
      end else begin
        if (mret) begin
          tgt         = epc;
          check_align = 1'b1;
        end else if (jump) begin
          tgt         = jump_target;
          check_align = 1'b1;
          taken       = 1'b1;
        end else if (branch_taken) begin
          tgt         = branch_target;
          check_align = 1'b1;
          taken       = 1'b1;
        end
        // A misaligned destination turns the redirect into a trap.
        if (check_align && !is_aligned(tgt)) begin
          misaligned = 1'b1;
          pc_next    = TRAP_VECTOR;
        end else begin
          pc_next  = tgt;
          redirect = taken;
        end
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the single-cycle core: BOOT/RUN/TRAP/HALT FSM,
// EPC and cause registers. Define PC_PERF_CNT_EN to add retire/taken counters.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h00000100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        trap_req,
  input  logic [3:0]  trap_cause_in,
  input  logic        mret,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        pc_valid,
  output logic [31:0] epc,
  output logic [3:0]  trap_cause,
  output logic [1:0]  state
`ifdef PC_PERF_CNT_EN
  ,
  output logic [63:0] instret_cnt,
  output logic [31:0] taken_cnt
`endif
);

  state_t      st_q, st_d;
  logic [31:0] pc_q, epc_q, sel_pc;
  logic [3:0]  cause_q;
  logic        redirect, misaligned, trap_entry;

  pc_next_sel #(.TRAP_VECTOR(TRAP_VECTOR)) u_sel (
    .st            (st_q),
    .pc            (pc_q),
    .epc           (epc_q),
    .stall         (stall),
    .halt_req      (halt_req),
    .trap_req      (trap_req),
    .mret          (mret),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_next       (sel_pc),
    .redirect      (redirect),
    .misaligned    (misaligned)
  );

  assign trap_entry = (st_q == ST_RUN) && !halt_req && !stall && (trap_req || misaligned);
  assign pc_next    = rst ? RESET_VECTOR : sel_pc;
  assign pc         = pc_q;
  assign pc_valid   = (st_q == ST_RUN);
  assign epc        = epc_q;
  assign trap_cause = cause_q;
  assign state      = st_q;

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_BOOT: st_d = ST_RUN;
      ST_TRAP: st_d = ST_RUN;
      ST_HALT: if (resume) st_d = ST_RUN;
      ST_RUN: begin
        if (halt_req)        st_d = ST_HALT;
        else if (trap_entry) st_d = ST_TRAP;
      end
      default: st_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      epc_q   <= 32'd0;
      cause_q <= 4'd0;
    end else begin
      st_q <= st_d;
      pc_q <= sel_pc;
      if (trap_entry) begin
        epc_q   <= pc_q;
        cause_q <= trap_req ? trap_cause_in : CAUSE_MISALIGNED;
      end
      // An accepted redirect and an alignment trap are mutually exclusive.
      assert (!(redirect && misaligned));
    end
  end

`ifdef PC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_cnt <= 64'd0;
      taken_cnt   <= 32'd0;
    end else begin
      if (st_q == ST_RUN && !stall && !halt_req && !trap_entry)
        instret_cnt <= instret_cnt + 64'd1;
      if (redirect)
        taken_cnt <= taken_cnt + 32'd1;
    end
  end
`endif

endmodule
